// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter in front of a single on-chip RAM port (registered address, unregistered data).
// One transfer per clock; read data is steered back to the master that issued the read.
module onchip_mem_arbiter #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 32,
  parameter int BE_W        = 4,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic act0_s;
  logic act1_s;
  logic gnt_valid_s;
  logic gnt_sel_s;
  logic win_read_s;
  logic last_grant_r;
  logic rd_pend_r;
  logic rd_owner_r;

  assign act0_s = m0_read | m0_write;
  assign act1_s = m1_read | m1_write;

  // Pick this cycle's winner; nothing is granted while reset is held
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_sel_s   = 1'b0;
    if (!reset_n) begin
      gnt_valid_s = 1'b0;
    end else if (act0_s && act1_s) begin
      gnt_valid_s = 1'b1;
      gnt_sel_s   = ROUND_ROBIN ? ~last_grant_r : 1'b0;
    end else if (act0_s) begin
      gnt_valid_s = 1'b1;
      gnt_sel_s   = 1'b0;
    end else if (act1_s) begin
      gnt_valid_s = 1'b1;
      gnt_sel_s   = 1'b1;
    end else begin
      gnt_valid_s = 1'b0;
    end
  end

  // Only the losing active master is stalled; idle masters see waitrequest low
  always_comb begin
    m0_waitrequest = 1'b0;
    m1_waitrequest = 1'b0;
    if (!reset_n) begin
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
    end else if (gnt_valid_s) begin
      m0_waitrequest = act0_s & gnt_sel_s;
      m1_waitrequest = act1_s & ~gnt_sel_s;
    end else begin
      m0_waitrequest = 1'b0;
      m1_waitrequest = 1'b0;
    end
  end

  // Steer the winner onto the RAM port; buses are zeroed when idle
  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = {ADDR_W{1'b0}};
    mem_byteenable = {BE_W{1'b0}};
    mem_writedata  = {DATA_W{1'b0}};
    win_read_s     = 1'b0;
    if (gnt_valid_s) begin
      mem_chipselect = 1'b1;
      if (gnt_sel_s) begin
        mem_write      = m1_write;
        mem_address    = m1_address;
        mem_byteenable = m1_byteenable;
        mem_writedata  = m1_writedata;
        win_read_s     = m1_read & ~m1_write;
      end else begin
        mem_write      = m0_write;
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        win_read_s     = m0_read & ~m0_write;
      end
    end else begin
      mem_chipselect = 1'b0;
    end
  end

  // Arbitration history and the one-deep read-return tracker
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= 1'b1;
      rd_pend_r    <= 1'b0;
      rd_owner_r   <= 1'b0;
    end else if (gnt_valid_s) begin
      last_grant_r <= gnt_sel_s;
      rd_pend_r    <= win_read_s;
      if (win_read_s) begin
        rd_owner_r <= gnt_sel_s;
      end else begin
        rd_owner_r <= rd_owner_r;
      end
    end else begin
      last_grant_r <= last_grant_r;
      rd_pend_r    <= 1'b0;
      rd_owner_r   <= rd_owner_r;
    end
  end

  assign m0_readdatavalid = rd_pend_r & ~rd_owner_r;
  assign m1_readdatavalid = rd_pend_r & rd_owner_r;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign mem_clken        = 1'b1;

endmodule
